// File: rtl/fft_frame_selector.sv
// fft_frame_selector: decimate valid samples into ping-pong FFT frames, stream them out, drop and count overflow frames
module fft_frame_selector #(
  parameter int DATA_W  = 16,
  parameter int FFT_LEN = 1024,
  parameter int DECIM_W = 8,
  parameter int DROP_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_enable,
  input  logic [DECIM_W-1:0] i_decim,
  input  logic               i_valid,
  input  logic [DATA_W-1:0]  i_data,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_last,
  output logic               o_frame_drop,
  output logic [DROP_W-1:0]  o_drop_count
);
  localparam int AW = $clog2(FFT_LEN);
  typedef enum logic [1:0] {IDLE, FILL, DISCARD} state_t;
  state_t r_state;
  logic [DECIM_W-1:0] r_dcnt, r_decq;
  logic [AW-1:0] r_waddr, r_raddr, w_ra;
  logic r_wbuf, r_rbuf, r_ract, r_old, r_v1, r_l1, r_b1, r_b2;
  logic [1:0] r_full, r_claim, w_cand, w_set, w_clr, w_cl;
  logic [DATA_W-1:0] mem [2*FFT_LEN];
  logic [DATA_W-1:0] r_rdata;
  logic w_keep, w_start, w_we, w_wdone, w_rb, w_ld2, w_ce1, w_issue;
  logic [AW:0] w_wa;
  always_comb begin
    w_keep = i_valid && r_dcnt == '0;
    w_start = r_state == IDLE && w_keep && i_enable;
    w_we = (w_start && !(&r_full)) || (r_state == FILL && w_keep);
    w_wa = w_start ? {r_full[0], {AW{1'b0}}} : {r_wbuf, r_waddr};
    w_wdone = r_state == FILL && w_keep && &r_waddr;
    w_cand = r_full & ~r_claim;
    w_rb = r_ract ? r_rbuf : (&w_cand ? r_old : w_cand[1]);
    w_ra = r_ract ? r_raddr : '0;
    w_ld2 = !o_valid || i_ready;
    w_ce1 = !r_v1 || w_ld2;
    w_issue = w_ce1 && (r_ract || |w_cand);
    w_set = w_wdone ? 2'b01 << r_wbuf : 2'b00;
    w_clr = (o_valid && i_ready && o_last) ? 2'b01 << r_b2 : 2'b00;
    w_cl = (w_issue && !r_ract) ? 2'b01 << w_rb : 2'b00;
  end
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= IDLE;
      r_dcnt <= '0;
      r_decq <= '0;
      r_waddr <= '0;
      r_wbuf <= 1'b0;
      o_frame_drop <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_frame_drop <= 1'b0;
      if (i_valid) r_dcnt <= r_dcnt == r_decq ? '0 : r_dcnt + DECIM_W'(1);
      if (w_keep) begin
        case (r_state)
          IDLE: if (i_enable) begin
            r_decq <= i_decim;
            r_dcnt <= DECIM_W'(i_decim != '0);
            r_wbuf <= r_full[0];
            r_waddr <= AW'(1);
            r_state <= &r_full ? DISCARD : FILL;
          end
          FILL, DISCARD: begin
            r_waddr <= r_waddr + AW'(1);
            if (&r_waddr) begin
              r_state <= IDLE;
              if (r_state == DISCARD) begin
                o_frame_drop <= 1'b1;
                o_drop_count <= o_drop_count + DROP_W'(!(&o_drop_count));
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (w_we) mem[w_wa] <= i_data;
    if (w_issue) r_rdata <= mem[{w_rb, w_ra}];
  end
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_full <= '0;
      r_claim <= '0;
      r_old <= 1'b0;
      r_ract <= 1'b0;
      r_rbuf <= 1'b0;
      r_raddr <= '0;
      r_v1 <= 1'b0;
      r_l1 <= 1'b0;
      r_b1 <= 1'b0;
      r_b2 <= 1'b0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_last <= 1'b0;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
      r_claim <= (r_claim | w_cl) & ~w_clr;
      if (w_wdone) r_old <= (r_full[!r_wbuf] && !w_clr[!r_wbuf]) ? !r_wbuf : r_wbuf;
      if (w_issue) begin
        r_v1 <= 1'b1;
        r_l1 <= &w_ra;
        r_b1 <= w_rb;
        r_rbuf <= w_rb;
        r_raddr <= w_ra + AW'(1);
        r_ract <= !(&w_ra);
      end else if (w_ce1) r_v1 <= 1'b0;
      if (w_ld2) begin
        o_valid <= r_v1;
        o_data <= r_v1 ? r_rdata : '0;
        o_last <= r_v1 && r_l1;
        r_b2 <= r_b1;
      end
    end
  end
endmodule
